// File: rtl/mcu_core_hs_if.sv
// Memory bus between the core and its instruction/data memories.
// The core drives the requests (master); the memory system answers with acks (slave).
interface mcu_core_hs_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
);
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic [15:0]       imem_rdata;
  logic              imem_ack;
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_rdata, imem_ack, dmem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_rdata, imem_ack, dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mcu_core_hs.sv
// Multi-cycle MCU core: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer with req/ack
// memory handshakes, 16-entry register file and {N,C,Z} flags.
module mcu_core_hs #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  mcu_core_hs_if.master     bus,
  output logic [PC_W-1:0]   pc,
  output logic [2:0]        flags,
  output logic              halted
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t            state_reg;
  logic [PC_W-1:0]   pc_reg;
  logic [2:0]        flags_reg;
  logic              halted_reg;
  logic [15:0]       ir_reg;
  logic [DATA_W-1:0] a_reg, b_reg, d_reg, result_reg;
  logic [DATA_W-1:0] regs [16];
  logic              imem_req_reg, dmem_req_reg, dmem_we_reg;
  logic [DATA_W-1:0] dmem_addr_reg, dmem_wdata_reg;

  logic [3:0] op, rd, ra, rb;
  assign op = ir_reg[15:12];
  assign rd = ir_reg[11:8];
  assign ra = ir_reg[7:4];
  assign rb = ir_reg[3:0];

  logic [DATA_W-1:0] imm4_ext, imm8_ext, alu_res, mem_addr;
  logic [DATA_W:0]   alu_wide;
  logic [PC_W-1:0]   target, pc_inc;
  logic              taken;

  assign imm4_ext = DATA_W'(rb);
  assign imm8_ext = DATA_W'({ra, rb});
  assign target   = PC_W'({ra, rb});
  assign pc_inc   = pc_reg + PC_W'(1);
  assign mem_addr = a_reg + imm4_ext;

  // The extra MSB of alu_wide is carry for adds and borrow for subtracts.
  always_comb begin
    alu_wide = '0;
    case (op)
      4'h1:       alu_wide = {1'b0, a_reg} + {1'b0, b_reg};
      4'h2, 4'h7: alu_wide = {1'b0, a_reg} - {1'b0, b_reg};
      4'h3:       alu_wide = {1'b0, a_reg & b_reg};
      4'h4:       alu_wide = {1'b0, a_reg | b_reg};
      4'h5:       alu_wide = {1'b0, a_reg ^ b_reg};
      4'h6:       alu_wide = {1'b0, a_reg} + {1'b0, imm4_ext};
      default:    alu_wide = '0;
    endcase
    alu_res = alu_wide[DATA_W-1:0];
  end

  always_comb begin
    taken = 1'b0;
    case (op)
      4'hB:    taken = flags_reg[0];
      4'hC:    taken = flags_reg[1];
      4'hD:    taken = flags_reg[2];
      4'hE:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_FETCH;
      pc_reg         <= '0;
      flags_reg      <= '0;
      halted_reg     <= 1'b0;
      ir_reg         <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      d_reg          <= '0;
      result_reg     <= '0;
      imem_req_reg   <= 1'b0;
      dmem_req_reg   <= 1'b0;
      dmem_we_reg    <= 1'b0;
      dmem_addr_reg  <= '0;
      dmem_wdata_reg <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          // Coming out of reset the request is raised here; later fetches arrive with it already up.
          if (!imem_req_reg) begin
            imem_req_reg <= 1'b1;
          end else if (bus.imem_ack) begin
            ir_reg       <= bus.imem_rdata;
            imem_req_reg <= 1'b0;
            state_reg    <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_reg     <= regs[ra];
          b_reg     <= regs[rb];
          d_reg     <= regs[rd];
          state_reg <= S_EXEC;
        end
        S_EXEC: begin
          if (op >= 4'h1 && op <= 4'h7)
            flags_reg <= {alu_res[DATA_W-1], alu_wide[DATA_W], alu_res == '0};
          result_reg <= (op == 4'hA) ? imm8_ext : alu_res;
          pc_reg     <= taken ? target : pc_inc;
          case (op)
            4'h8, 4'h9: begin
              dmem_req_reg   <= 1'b1;
              dmem_we_reg    <= (op == 4'h9);
              dmem_addr_reg  <= mem_addr;
              dmem_wdata_reg <= d_reg;
              state_reg      <= S_MEM;
            end
            4'h0, 4'h7, 4'hB, 4'hC, 4'hD, 4'hE: begin
              imem_req_reg <= 1'b1;
              state_reg    <= S_FETCH;
            end
            4'hF: begin
              halted_reg <= 1'b1;
              state_reg  <= S_HALT;
            end
            default: state_reg <= S_WB;
          endcase
        end
        S_MEM: begin
          if (bus.dmem_ack) begin
            dmem_req_reg <= 1'b0;
            dmem_we_reg  <= 1'b0;
            if (op == 4'h8) begin
              result_reg <= bus.dmem_rdata;
              state_reg  <= S_WB;
            end else begin
              imem_req_reg <= 1'b1;
              state_reg    <= S_FETCH;
            end
          end
        end
        S_WB: begin
          if (rd != 4'h0) regs[rd] <= result_reg;
          imem_req_reg <= 1'b1;
          state_reg    <= S_FETCH;
        end
        S_HALT: state_reg <= S_HALT;
        default: state_reg <= S_FETCH;
      endcase
    end
  end

  assign bus.imem_req   = imem_req_reg;
  assign bus.imem_addr  = pc_reg;
  assign bus.dmem_req   = dmem_req_reg;
  assign bus.dmem_we    = dmem_we_reg;
  assign bus.dmem_addr  = dmem_addr_reg;
  assign bus.dmem_wdata = dmem_wdata_reg;
  assign pc             = pc_reg;
  assign flags          = flags_reg;
  assign halted         = halted_reg;
endmodule
